// File: rtl/d7s_pkg.sv
// Shared constants for the three-digit seven-segment display controller.
// Segment codes are active-low, bit6..0 = g,f,e,d,c,b,a.
package d7s_pkg;

  localparam int DATA_W = 8;
  localparam int BCD_W  = 12;
  localparam int CNT_W  = 3;

  typedef logic [6:0] seg_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;

  // Double-dabble correction applied to a nibble before each left shift.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to active-low seven-segment code, with a blank override.
module seg7_encode
  import d7s_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output seg_t       code
);

  always_comb begin
    code = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    code = SEG_0;
        4'd1:    code = SEG_1;
        4'd2:    code = SEG_2;
        4'd3:    code = SEG_3;
        4'd4:    code = SEG_4;
        4'd5:    code = SEG_5;
        4'd6:    code = SEG_6;
        4'd7:    code = SEG_7;
        4'd8:    code = SEG_8;
        4'd9:    code = SEG_9;
        default: code = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/d7s_ctrl.sv
// Display controller: captures an 8-bit value, converts it to BCD one bit per
// cycle, commits three digit registers and scans them onto a shared segment bus.
module d7s_ctrl
  import d7s_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [6:0]        Y0,
  output logic [6:0]        Y1,
  output logic [6:0]        Y2,
  output logic [6:0]        seg,
  output logic [2:0]        an
);

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [1:0]              state_q;
  logic [DATA_W-1:0]       shift_q;
  logic [BCD_W-1:0]        bcd_q;
  logic [CNT_W-1:0]        bitcnt_q;
  logic                    pend_q;
  logic [DATA_W-1:0]       pend_data_q;
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W+DATA_W-1:0] pair;
  logic                    hund_blank;
  logic                    tens_blank;
  seg_t                    enc0, enc1, enc2;
  logic [SCAN_W-1:0]       scan_cnt_q;
  logic [1:0]              scan_idx_q;

  always_comb begin
    bcd_adj    = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    pair       = {bcd_adj, shift_q};
    hund_blank = BLANK_LZ && (bcd_q[11:8] == 4'd0);
    tens_blank = hund_blank && (bcd_q[7:4] == 4'd0);
  end

  seg7_encode u_enc0 (.digit(bcd_q[3:0]),  .blank(1'b0),       .code(enc0));
  seg7_encode u_enc1 (.digit(bcd_q[7:4]),  .blank(tens_blank), .code(enc1));
  seg7_encode u_enc2 (.digit(bcd_q[11:8]), .blank(hund_blank), .code(enc2));

  assign busy = (state_q != ST_IDLE);

  // A write landing on the COMMIT cycle with nothing pending is parked and
  // picked up from IDLE on the following cycle, so it is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bcd_q       <= '0;
      bitcnt_q    <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      done        <= 1'b0;
      Y0          <= SEG_0;
      Y1          <= BLANK_LZ ? SEG_BLANK : SEG_0;
      Y2          <= BLANK_LZ ? SEG_BLANK : SEG_0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wr_en || pend_q) begin
            shift_q  <= wr_en ? wr_data : pend_data_q;
            bcd_q    <= '0;
            bitcnt_q <= '0;
            pend_q   <= 1'b0;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd_q, shift_q} <= pair << 1;
          bitcnt_q         <= bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_q <= ST_COMMIT;
          if (wr_en) begin
            pend_q      <= 1'b1;
            pend_data_q <= wr_data;
          end
        end
        ST_COMMIT: begin
          Y0   <= enc0;
          Y1   <= enc1;
          Y2   <= enc2;
          done <= 1'b1;
          if (pend_q) begin
            shift_q  <= pend_data_q;
            bcd_q    <= '0;
            bitcnt_q <= '0;
            pend_q   <= wr_en;
            state_q  <= ST_SHIFT;
          end else begin
            pend_q  <= wr_en;
            state_q <= ST_IDLE;
          end
          if (wr_en) pend_data_q <= wr_data;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= 2'd0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q <= '0;
      scan_idx_q <= (scan_idx_q == 2'd2) ? 2'd0 : scan_idx_q + 2'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  always_comb begin
    seg = Y0;
    an  = 3'b110;
    case (scan_idx_q)
      2'd1: begin seg = Y1; an = 3'b101; end
      2'd2: begin seg = Y2; an = 3'b011; end
      default: begin seg = Y0; an = 3'b110; end
    endcase
  end

endmodule

// File: tb/tb_d7s_ctrl.sv
// Bench for d7s_ctrl: two instances (leading-zero blanking on and off) share
// stimulus and are compared every cycle against a decimal-arithmetic model.
module tb_d7s_ctrl;

  localparam int SD = 4;

  logic       clk, rst_n, wr_en;
  logic [7:0] wr_data;
  logic       busy_b, done_b, busy_n, done_n;
  logic [6:0] y0_b, y1_b, y2_b, seg_b, y0_n, y1_n, y2_n, seg_n;
  logic [2:0] an_b, an_n;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  d7s_ctrl #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy_b), .done(done_b), .Y0(y0_b), .Y1(y1_b), .Y2(y2_b),
    .seg(seg_b), .an(an_b));

  d7s_ctrl #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy_n), .done(done_n), .Y0(y0_n), .Y1(y1_n), .Y2(y2_n),
    .seg(seg_n), .an(an_n));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] digitSeg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected segment code of digit position pos when value val is displayed.
  function automatic logic [6:0] expY(input int val, input int pos, input bit blz);
    int h, t, u;
    h = val / 100;
    t = (val / 10) % 10;
    u = val % 10;
    if (pos == 0) return digitSeg(u);
    if (pos == 1) return (blz && h == 0 && t == 0) ? 7'b1111111 : digitSeg(t);
    return (blz && h == 0) ? 7'b1111111 : digitSeg(h);
  endfunction

  // Model: a conversion takes 9 edges; the display shows the last committed value.
  int m_cnt, m_val, m_pval, m_disp, m_tick;
  bit m_pend, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_val <= 0; m_pval <= 0; m_disp <= 0; m_tick <= 0;
      m_pend <= 0; m_done <= 0;
    end else begin
      m_tick <= m_tick + 1;
      m_done <= 0;
      if (m_cnt == 0) begin
        if (wr_en) begin
          m_val <= int'(wr_data); m_cnt <= 9; m_pend <= 0;
        end else if (m_pend) begin
          m_val <= m_pval; m_cnt <= 9; m_pend <= 0;
        end
      end else if (m_cnt == 1) begin
        m_disp <= m_val;
        m_done <= 1;
        if (m_pend) begin
          m_val <= m_pval; m_cnt <= 9;
        end else begin
          m_cnt <= 0;
        end
        m_pend <= wr_en;
        if (wr_en) m_pval <= int'(wr_data);
      end else begin
        m_cnt <= m_cnt - 1;
        if (wr_en) begin
          m_pend <= 1; m_pval <= int'(wr_data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareDut(input string tag, input bit blz, input logic busy, input logic done,
                            input logic [6:0] y0, input logic [6:0] y1, input logic [6:0] y2,
                            input logic [6:0] sg, input logic [2:0] an);
    int idx;
    logic [6:0] ey [3];
    idx = (m_tick / SD) % 3;
    for (int p = 0; p < 3; p++) ey[p] = expY(m_disp, p, blz);
    checkOutput({tag, "_busy"}, int'(busy), int'(m_cnt != 0));
    checkOutput({tag, "_done"}, int'(done), int'(m_done));
    checkOutput({tag, "_y0"}, int'(y0), int'(ey[0]));
    checkOutput({tag, "_y1"}, int'(y1), int'(ey[1]));
    checkOutput({tag, "_y2"}, int'(y2), int'(ey[2]));
    checkOutput({tag, "_seg"}, int'(sg), int'(ey[idx]));
    checkOutput({tag, "_an"}, int'(an), int'(~(3'b001 << idx) & 3'b111));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      compareDut("blz", 1'b1, busy_b, done_b, y0_b, y1_b, y2_b, seg_b, an_b);
      compareDut("nolz", 1'b0, busy_n, done_n, y0_n, y1_n, y2_n, seg_n, an_n);
    end
  end

  // Drives inputs just after a falling edge so they are sampled at the next rising edge.
  task automatic applyStimulus(input logic we, input logic [7:0] data);
    @(negedge clk);
    #1;
    wr_en   = we;
    wr_data = data;
  endtask

  task automatic waitDone(input string name, input int expected);
    int n;
    n = 0;
    while (n <= 30) begin
      @(negedge clk);
      n++;
      if (done_b) break;
    end
    checkOutput(name, n, expected);
  endtask

  task automatic checkDigits(input string name, input logic [6:0] e2, input logic [6:0] e1,
                             input logic [6:0] e0);
    checkOutput({name, "_Y2"}, int'(y2_b), int'(e2));
    checkOutput({name, "_Y1"}, int'(y1_b), int'(e1));
    checkOutput({name, "_Y0"}, int'(y0_b), int'(e0));
  endtask

  initial begin
    bit found;
    logic [2:0] prev_an;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'd0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;

    checkDigits("reset_blz", 7'b1111111, 7'b1111111, 7'b1000000);
    checkOutput("reset_nolz_Y1", int'(y1_n), 7'b1000000);
    checkOutput("reset_an", int'(an_b), 3'b110);
    checkOutput("reset_busy", int'(busy_b), 0);

    applyStimulus(1'b1, 8'd255);
    applyStimulus(1'b0, 8'd0);
    checkOutput("busy_after_write", int'(busy_b), 1);
    waitDone("latency_255", 9);
    checkDigits("val_255", 7'b0100100, 7'b0010010, 7'b0010010);
    checkOutput("busy_after_done", int'(busy_b), 0);

    applyStimulus(1'b1, 8'd7);
    applyStimulus(1'b0, 8'd0);
    waitDone("latency_7", 9);
    checkDigits("val_7", 7'b1111111, 7'b1111111, 7'b1111000);

    applyStimulus(1'b1, 8'd100);
    applyStimulus(1'b0, 8'd0);
    waitDone("latency_100", 9);
    checkDigits("val_100", 7'b1111001, 7'b1000000, 7'b1000000);

    applyStimulus(1'b1, 8'd0);
    applyStimulus(1'b0, 8'd0);
    waitDone("latency_0", 9);
    checkOutput("nolz_0_Y2", int'(y2_n), 7'b1000000);
    checkOutput("nolz_0_Y1", int'(y1_n), 7'b1000000);
    checkOutput("nolz_0_Y0", int'(y0_n), 7'b1000000);

    // 12 at edge 0, 34 at edge 3, 56 at edge 5: 56 overwrites 34 in pending.
    applyStimulus(1'b1, 8'd12);
    applyStimulus(1'b0, 8'd0);
    applyStimulus(1'b0, 8'd0);
    applyStimulus(1'b1, 8'd34);
    applyStimulus(1'b0, 8'd0);
    applyStimulus(1'b1, 8'd56);
    applyStimulus(1'b0, 8'd0);
    waitDone("latency_12", 4);
    checkDigits("val_12", 7'b1111111, 7'b1111001, 7'b0100100);
    waitDone("latency_56", 9);
    checkDigits("val_56", 7'b1111111, 7'b0010010, 7'b0000010);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("no_third_done", int'(done_b), 0);
    end

    applyStimulus(1'b1, 8'd200);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'd0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy_b), 0);
    checkDigits("abort_reset", 7'b1111111, 7'b1111111, 7'b1000000);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("abort_no_done", int'(done_b), 0);
    end

    applyStimulus(1'b1, 8'd9);
    applyStimulus(1'b0, 8'd0);
    waitDone("latency_9", 9);
    checkDigits("val_9", 7'b1111111, 7'b1111111, 7'b0010000);
    checkOutput("nolz_9_Y1", int'(y1_n), 7'b1000000);

    applyStimulus(1'b1, 8'd123);
    applyStimulus(1'b0, 8'd0);
    waitDone("latency_123", 9);
    found = 0;
    prev_an = an_b;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (prev_an != 3'b110 && an_b == 3'b110) found = 1;
      prev_an = an_b;
    end
    checkOutput("scan_sync", int'(found), 1);
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < SD; k++) begin
        case (p)
          0: begin
            checkOutput("scan_an0", int'(an_b), 3'b110);
            checkOutput("scan_seg0", int'(seg_b), 7'b0110000);
          end
          1: begin
            checkOutput("scan_an1", int'(an_b), 3'b101);
            checkOutput("scan_seg1", int'(seg_b), 7'b0100100);
          end
          default: begin
            checkOutput("scan_an2", int'(an_b), 3'b011);
            checkOutput("scan_seg2", int'(seg_b), 7'b1111001);
          end
        endcase
        @(negedge clk);
      end
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
